// File: rtl/qsys_spi_slave.sv
// qsys_spi_slave: SPI slave (CPOL 0, CPHA 0, MSB first) with a 16-bit CPU register port.
// Ports: clk/reset_n (async, active-low); data_from_cpu, mem_addr, read_n, write_n and
// spi_select form a two-cycle register port; data_to_cpu is the registered read data.
// SCLK, SS_n and MOSI come from the SPI master and MISO goes back to it.
// dataavailable (RRDY), readyfordata (TRDY), endofpacket (EOP) and irq are status outputs.
module qsys_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_from_cpu,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic [15:0] data_to_cpu,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket,
  output logic        irq
);
  localparam logic [2:0] LAST_BIT = 3'(DATABITS - 1);
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, ss_dly_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, frame_start, frame_end;
  logic                   rd_stb_q, wr_stb_q, rd_stb, wr_stb;
  logic                   wr_tx, wr_status, wr_ctrl, wr_eopv, rd_rx;
  logic                   frame_q, frame_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   byte_done_q, byte_done_d;
  logic                   deliver_q, deliver_d;
  logic                   rx_bit_q, rx_bit_d;
  logic [DATABITS-1:0]    shift_q, shift_d, shift_in, load_val;
  logic [DATABITS-1:0]    rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
  logic                   tx_primed_q, tx_primed_d;
  logic                   rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, eop_q, eop_d;
  logic [15:0]            ctrl_q, ctrl_d, eopv_q, eopv_d;
  logic                   byte_last, reload, consume, tx_accept;
  logic [15:0]            status, rdata;
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_dly_q;
  assign sclk_fall   = ~sclk_s & sclk_dly_q;
  assign frame_start = ss_dly_q & ~ss_s;
  assign frame_end   = ~ss_dly_q & ss_s;
  assign rd_stb      = ~rd_stb_q & spi_select & ~read_n;
  assign wr_stb      = ~wr_stb_q & spi_select & ~write_n;
  assign wr_tx       = wr_stb & (mem_addr == 3'd1);
  assign wr_status   = wr_stb & (mem_addr == 3'd2);
  assign wr_ctrl     = wr_stb & (mem_addr == 3'd3);
  assign wr_eopv     = wr_stb & (mem_addr == 3'd6);
  // RRDY is consumed in the second cycle of an rxdata read
  assign rd_rx       = rd_stb_q & (mem_addr == 3'd0);
  assign byte_last   = frame_q & sclk_rise & (bitcnt_q == LAST_BIT);
  assign reload      = frame_q & sclk_fall & byte_done_q;
  // A write landing while the held byte is being consumed becomes the next primed byte
  assign consume     = (frame_start | reload) & tx_primed_q;
  assign tx_accept   = wr_tx & (~tx_primed_q | consume);
  assign shift_in    = {shift_q[DATABITS-2:0], rx_bit_q};
  assign load_val    = tx_primed_q ? tx_hold_q : '0;
  assign status      = {6'b0, eop_q, roe_q | toe_q, rrdy_q, ~tx_primed_q,
                        ~tx_primed_q & ~frame_q, toe_q, roe_q, 3'b0};
  assign rdata       = (mem_addr == 3'd2) ? status :
                       (mem_addr == 3'd3) ? ctrl_q :
                       (mem_addr == 3'd6) ? eopv_q : {{(16-DATABITS){1'b0}}, rx_hold_q};
  assign MISO          = frame_q & shift_q[DATABITS-1];
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~tx_primed_q;
  assign endofpacket   = eop_q;
  always_comb begin
    frame_d     = frame_start | (frame_q & ~frame_end);
    bitcnt_d    = (frame_start | frame_end) ? 3'd0 :
                  (frame_q & sclk_rise) ? bitcnt_q + 3'd1 : bitcnt_q;
    byte_done_d = (frame_start | frame_end | reload) ? 1'b0 : (byte_last | byte_done_q);
    deliver_d   = byte_last;
    rx_bit_d    = (frame_q & sclk_rise) ? mosi_s : rx_bit_q;
    shift_d     = (frame_start | reload) ? load_val :
                  (frame_q & sclk_fall & ~byte_done_q) ? shift_in : shift_q;
    rx_hold_d   = deliver_q ? shift_in : rx_hold_q;
    tx_hold_d   = tx_accept ? data_from_cpu[DATABITS-1:0] : tx_hold_q;
    tx_primed_d = tx_accept | (tx_primed_q & ~consume);
    // A completing byte wins over a status write or an rxdata read in the same cycle
    rrdy_d      = deliver_q | (rrdy_q & ~rd_rx & ~wr_status);
    roe_d       = (deliver_q & rrdy_q & ~rd_rx) | (roe_q & ~wr_status);
    toe_d       = (wr_tx & ~tx_accept) | (toe_q & ~wr_status);
    eop_d       = (deliver_q & (shift_in == eopv_q[DATABITS-1:0])) |
                  (wr_tx & (data_from_cpu[DATABITS-1:0] == eopv_q[DATABITS-1:0])) |
                  (rd_rx & (rx_hold_q == eopv_q[DATABITS-1:0])) |
                  (eop_q & ~wr_status);
    ctrl_d      = wr_ctrl ? (data_from_cpu & 16'h03D8) : ctrl_q;
    eopv_d      = wr_eopv ? data_from_cpu : eopv_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      frame_q     <= 1'b0;
      bitcnt_q    <= 3'd0;
      byte_done_q <= 1'b0;
      deliver_q   <= 1'b0;
      rx_bit_q    <= 1'b0;
      shift_q     <= '0;
      rx_hold_q   <= '0;
      tx_hold_q   <= '0;
      tx_primed_q <= 1'b0;
      rrdy_q      <= 1'b0;
      roe_q       <= 1'b0;
      toe_q       <= 1'b0;
      eop_q       <= 1'b0;
      ctrl_q      <= '0;
      eopv_q      <= '0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
      rd_stb_q    <= rd_stb;
      wr_stb_q    <= wr_stb;
      frame_q     <= frame_d;
      bitcnt_q    <= bitcnt_d;
      byte_done_q <= byte_done_d;
      deliver_q   <= deliver_d;
      rx_bit_q    <= rx_bit_d;
      shift_q     <= shift_d;
      rx_hold_q   <= rx_hold_d;
      tx_hold_q   <= tx_hold_d;
      tx_primed_q <= tx_primed_d;
      rrdy_q      <= rrdy_d;
      roe_q       <= roe_d;
      toe_q       <= toe_d;
      eop_q       <= eop_d;
      ctrl_q      <= ctrl_d;
      eopv_q      <= eopv_d;
      data_to_cpu <= rdata;
      irq         <= |(status & ctrl_q);
    end
  end
endmodule

// File: tb/tb_qsys_spi_slave.sv
// tb_qsys_spi_slave: directed bench for qsys_spi_slave against a register/byte-level model.
module tb_qsys_spi_slave;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [15:0] data_from_cpu = '0;
  logic [2:0]  mem_addr = '0;
  logic        read_n = 1'b1, write_n = 1'b1, spi_select = 1'b0;
  logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic        MISO, dataavailable, readyfordata, endofpacket, irq;
  logic [15:0] data_to_cpu;
  int          vectors = 0, miscompares = 0;
  bit          settled = 1'b0;
  logic        m_rrdy, m_roe, m_toe, m_eop, m_primed;
  logic [7:0]  m_txhold, m_rxhold;
  logic [15:0] m_ctrl, m_eopv;
  logic [15:0] v;
  logic [7:0]  mb;

  qsys_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .data_from_cpu(data_from_cpu), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select), .SCLK(SCLK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .data_to_cpu(data_to_cpu), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .endofpacket(endofpacket), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0; m_primed = 0;
    m_txhold = 0; m_rxhold = 0; m_ctrl = 0; m_eopv = 0;
  endtask

  // Status as seen with no frame in progress
  function automatic logic [15:0] m_status();
    return {6'b0, m_eop, m_roe | m_toe, m_rrdy, !m_primed, !m_primed, m_toe, m_roe, 3'b0};
  endfunction

  task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
    settled = 0;
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    tick(2);
    spi_select = 0; write_n = 1;
    if (a == 3'd1) begin
      if (!m_primed) begin m_txhold = d[7:0]; m_primed = 1; end
      else m_toe = 1;
      if (d[7:0] == m_eopv[7:0]) m_eop = 1;
    end else if (a == 3'd2) begin
      m_eop = 0; m_rrdy = 0; m_roe = 0; m_toe = 0;
    end else if (a == 3'd3) m_ctrl = d & 16'h03D8;
    else if (a == 3'd6) m_eopv = d;
    tick(3);
    settled = 1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [15:0] got);
    logic [15:0] exp;
    settled = 0;
    exp = (a == 3'd2) ? m_status() : (a == 3'd3) ? m_ctrl : (a == 3'd6) ? m_eopv : {8'h00, m_rxhold};
    spi_select = 1; read_n = 0; mem_addr = a;
    tick(2);
    got = data_to_cpu;
    chk("read_data", got, exp);
    spi_select = 0; read_n = 1;
    if (a == 3'd0) begin
      m_rrdy = 0;
      if (m_rxhold == m_eopv[7:0]) m_eop = 1;
    end
    tick(3);
    settled = 1;
  endtask

  // Master frame of nbits bits taken MSB first from d; first_miso collects the first 8 MISO bits
  task automatic spi_xfer(input logic [31:0] d, input int nbits, output logic [7:0] first_miso);
    logic [7:0] out, rxb;
    settled = 0;
    first_miso = 0; rxb = 0;
    out = m_primed ? m_txhold : 8'h00;
    m_primed = 0;
    SS_n = 0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      MOSI = d[nbits-1-i];
      tick(6);
      chk("miso_bit", {15'b0, MISO}, {15'b0, out[7-(i%8)]});
      if (i < 8) first_miso = {first_miso[6:0], MISO};
      rxb = {rxb[6:0], MOSI};
      SCLK = 1;
      tick(6);
      SCLK = 0;
      if (i % 8 == 7) begin
        if (m_rrdy) m_roe = 1;
        m_rrdy = 1;
        m_rxhold = rxb;
        if (rxb == m_eopv[7:0]) m_eop = 1;
        out = m_primed ? m_txhold : 8'h00;
        m_primed = 0;
      end
    end
    tick(6);
    SS_n = 1; MOSI = 0;
    tick(6);
    settled = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (settled) begin
        chk("dataavailable", {15'b0, dataavailable}, {15'b0, m_rrdy});
        chk("readyfordata", {15'b0, readyfordata}, {15'b0, !m_primed});
        chk("endofpacket", {15'b0, endofpacket}, {15'b0, m_eop});
        chk("irq", {15'b0, irq}, {15'b0, |(m_status() & m_ctrl)});
        chk("miso_idle", {15'b0, MISO}, 16'h0000);
      end
    end
  end

  initial begin
    model_reset();
    tick(3);
    chk("rst_miso", {15'b0, MISO}, 16'h0000);
    chk("rst_data", data_to_cpu, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_rrdy", {15'b0, dataavailable}, 16'h0000);
    chk("rst_trdy", {15'b0, readyfordata}, 16'h0001);
    chk("rst_eop", {15'b0, endofpacket}, 16'h0000);
    reset_n = 1;
    tick(3);
    settled = 1;
    cpu_rd(3'd2, v);   chk("status_after_reset", v, 16'h0060);
    // basic transfer
    cpu_wr(3'd1, 16'h00A5);
    spi_xfer(32'h3C, 8, mb);  chk("miso_a5", {8'h00, mb}, 16'h00A5);
    chk("rrdy_set", {15'b0, dataavailable}, 16'h0001);
    cpu_rd(3'd0, v);   chk("rx_3c", v, 16'h003C);
    chk("rrdy_clr", {15'b0, dataavailable}, 16'h0000);
    // back-to-back bytes with overrun
    cpu_wr(3'd3, 16'h0008);
    cpu_wr(3'd1, 16'h0011);
    spi_xfer(32'h0102, 16, mb); chk("miso_11", {8'h00, mb}, 16'h0011);
    chk("irq_roe", {15'b0, irq}, 16'h0001);
    cpu_rd(3'd2, v);   chk("status_roe", v, 16'h01E8);
    cpu_rd(3'd0, v);   chk("rx_02", v, 16'h0002);
    cpu_wr(3'd2, 16'h0000);
    chk("irq_clr", {15'b0, irq}, 16'h0000);
    // transmit overrun
    cpu_wr(3'd3, 16'h0100);
    cpu_wr(3'd1, 16'h0033);
    cpu_wr(3'd1, 16'h0044);
    cpu_rd(3'd2, v);   chk("status_toe", v, 16'h0110);
    chk("irq_e", {15'b0, irq}, 16'h0001);
    cpu_wr(3'd2, 16'h0000);
    cpu_rd(3'd2, v);   chk("status_toe_clr", v, 16'h0000);
    spi_xfer(32'h55, 8, mb);  chk("miso_33", {8'h00, mb}, 16'h0033);
    cpu_rd(3'd0, v);   chk("rx_55", v, 16'h0055);
    // end of packet
    cpu_wr(3'd6, 16'h007E);
    cpu_wr(3'd3, 16'h0200);
    cpu_wr(3'd1, 16'h007E);
    chk("eop_txwr", {15'b0, endofpacket}, 16'h0001);
    cpu_wr(3'd2, 16'h0000);
    chk("eop_clr", {15'b0, endofpacket}, 16'h0000);
    spi_xfer(32'h7E, 8, mb);  chk("miso_7e", {8'h00, mb}, 16'h007E);
    chk("eop_rx", {15'b0, endofpacket}, 16'h0001);
    chk("irq_eop", {15'b0, irq}, 16'h0001);
    cpu_rd(3'd6, v);   chk("eop_value", v, 16'h007E);
    cpu_rd(3'd0, v);   chk("rx_7e", v, 16'h007E);
    cpu_wr(3'd2, 16'h0000);
    cpu_wr(3'd3, 16'h0000);
    // partial frame is discarded
    cpu_wr(3'd1, 16'h0096);
    spi_xfer(32'h9, 4, mb);   chk("miso_partial", {8'h00, mb}, 16'h0009);
    chk("rrdy_partial", {15'b0, dataavailable}, 16'h0000);
    spi_xfer(32'hC3, 8, mb);  chk("miso_zero", {8'h00, mb}, 16'h0000);
    cpu_rd(3'd0, v);   chk("rx_c3", v, 16'h00C3);
    // reset in the middle of a frame
    cpu_wr(3'd1, 16'h005A);
    settled = 0;
    SS_n = 0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'(i & 1);
      tick(6);
      SCLK = 1;
      tick(6);
      SCLK = 0;
    end
    reset_n = 0;
    #1;
    chk("mid_rst_miso", {15'b0, MISO}, 16'h0000);
    chk("mid_rst_data", data_to_cpu, 16'h0000);
    chk("mid_rst_irq", {15'b0, irq}, 16'h0000);
    chk("mid_rst_rrdy", {15'b0, dataavailable}, 16'h0000);
    chk("mid_rst_trdy", {15'b0, readyfordata}, 16'h0001);
    chk("mid_rst_eop", {15'b0, endofpacket}, 16'h0000);
    model_reset();
    SS_n = 1; MOSI = 0;
    tick(4);
    reset_n = 1;
    tick(3);
    settled = 1;
    cpu_rd(3'd2, v);   chk("status_after_mid_rst", v, 16'h0060);
    cpu_wr(3'd1, 16'h0081);
    spi_xfer(32'h24, 8, mb);  chk("miso_81", {8'h00, mb}, 16'h0081);
    cpu_rd(3'd0, v);   chk("rx_24", v, 16'h0024);
    settled = 0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/qsys_spi_slave.md
QSYS_SPI_SLAVE -- requirements
Module: qsys_spi_slave

Interface
REQ-001 SHALL provide parameter: DATABITS, 8, SPI word width (only 8 supported).
REQ-002 SHALL provide parameter: SYNC_STAGES, 2, flip-flop depth of the SCLK/SS_n/MOSI synchronisers.
REQ-003 SHALL have ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- data_from_cpu  in  16  register write data.
- mem_addr  in  3  register address.
- read_n  in  1  read request, active low.
- write_n  in  1  write request, active low.
- spi_select  in  1  chip select for the register port.
- SCLK  in  1  SPI clock from the master (CPOL 0, CPHA 0, MSB first).
- SS_n  in  1  slave select from the master, active low.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial data to the master.
- data_to_cpu  out  16  registered read data.
- dataavailable  out  1  RRDY.
- readyfordata  out  1  TRDY.
- endofpacket  out  1  EOP.
- irq  out  1  registered interrupt.

Function
REQ-004 Register map SHALL be: 0 rxdata (r); 1 txdata (w); 2 status (r; any write clears EOP, RRDY, ROE, TOE); 3 control (r/w); 6 eop-value (r/w, 16 bit). Other addresses SHALL read rxdata and ignore writes.
REQ-005 Reads and writes SHALL be two-cycle:
- strobe = ~strobe_q & spi_select & ~read_n (or ~write_n);
- strobe_q is the registered strobe;
- data_to_cpu SHALL be registered every cycle from the mem_addr mux.
REQ-006 Status word SHALL be {EOP[9], E[8]=ROE|TOE, RRDY[7], TRDY[6], TMT[5], TOE[4], ROE[3], 3'b0}.
REQ-007 Status flags SHALL be defined as:
- TRDY = ~tx_primed;
- TMT = ~tx_primed & ~frame_active.
REQ-008 Control word SHALL be {iEOP[9], iE[8], iRRDY[7], iTRDY[6], 1'b0, iTOE[4], iROE[3], 3'b0}.
REQ-009 irq SHALL register, each clk, the OR of each status flag ANDed with its enable.
REQ-010 SCLK, SS_n and MOSI SHALL each pass through a SYNC_STAGES synchroniser.
REQ-011 sclk_rise and sclk_fall SHALL be single-clk pulses derived from the synchronised SCLK and its one-cycle delay.
REQ-012 Frame start (synchronised SS_n 1->0) SHALL:
- set frame_active;
- clear bitcount (3 bit);
- load shift_reg with tx_holding if tx_primed, else 8'h00;
- clear tx_primed.
REQ-013 MISO SHALL equal shift_reg[7] while frame_active, else 0.
REQ-014 On sclk_rise with frame_active:
- SHALL capture MOSI into rx_bit;
- SHALL increment bitcount modulo 8;
- when bitcount==7, SHALL set byte_done.
REQ-015 On sclk_fall with frame_active and byte_done clear, shift_reg SHALL become {shift_reg[6:0], rx_bit}.
REQ-016 When byte_done is set, the next clk SHALL:
- write rx_holding = {shift_reg[6:0], rx_bit};
- set RRDY;
- set ROE if RRDY was already 1;
- set EOP if the byte equals eop-value[7:0].
REQ-017 The sclk_fall following byte_done SHALL:
- reload shift_reg from tx_holding if tx_primed (clearing tx_primed), else from 8'h00;
- clear byte_done.
Back-to-back bytes SHALL be supported under a single SS_n assertion.
REQ-018 Synchronised SS_n 0->1 SHALL:
- clear frame_active, bitcount and byte_done;
- discard a partial byte without setting RRDY;
- leave a byte completed in the same cycle delivered.
REQ-019 txdata write SHALL:
- store data_from_cpu[7:0] and set tx_primed when TRDY=1;
- when TRDY=0, set TOE and discard the data.
In both cases, data_from_cpu[7:0]==eop-value SHALL set EOP.
REQ-020 rxdata read SHALL clear RRDY on the second cycle.
REQ-021 rxdata read SHALL set EOP when rx_holding equals eop-value.
REQ-022 Simultaneous events SHALL resolve as follows:
- byte completion beats rxdata read: RRDY stays 1, ROE not set;
- byte completion beats status write: RRDY=1, ROE/EOP per REQ-016;
- txdata write in the cycle of a frame-start or reload that consumes tx_holding: the write is accepted as a new primed byte.
REQ-023 Timing SHALL meet the following:
- correct operation requires each SCLK phase ≥ 3 clk;
- SS_n falling to first SCLK rise ≥ 4 clk;
- slower SCLK SHALL not affect function.

Reset
REQ-024 reset_n low SHALL asynchronously clear:
- MISO, data_to_cpu, irq, dataavailable, endofpacket;
- shift_reg, rx_holding, tx_holding, tx_primed;
- bitcount, byte_done, frame_active;
- all status and control bits, eop-value.
REQ-025 reset_n low SHALL set readyfordata=1 and the synchronised SS_n to 1, SCLK to 0, MOSI to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame.
REQ-027 After reset release, the block SHALL wait for a fresh SS_n falling edge before shifting.

Verification
REQ-028 Write txdata 0xA5; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RRDY=1; rxdata reads 0x003C; RRDY=0 after read.
REQ-029 Prime 0x11; master sends 0x01,0x02 under one SS_n -> MISO 0x11 then 0x00; rx 0x01 then 0x02; ROE=1 if 0x01 unread; irq=1 when iROE=1.
REQ-030 Write txdata twice without a frame -> TOE=1, E=1; first byte kept; status write -> TOE=0, E=0.
REQ-031 eop-value=0x7E; master sends 0x7E -> EOP=1, endofpacket=1; irq=1 with iEOP=1.
REQ-032 SS_n deasserted after 4 SCLK rises -> RRDY stays 0; the next full frame receives correctly.
REQ-033 reset_n pulsed mid-frame -> all outputs at reset values; readyfordata=1; next frame is correct.
